// File: rtl/rs_pkg.sv
// Shared ALU op encoding used by the LSB, decoder and reservation stations.
package rs_pkg;

    localparam int OP_W = 4;

    typedef logic [OP_W-1:0] aluOp_t;

    localparam aluOp_t OP_ADD = 4'd0;
    localparam aluOp_t OP_SUB = 4'd1;
    localparam aluOp_t OP_SLL = 4'd2;
    localparam aluOp_t OP_XOR = 4'd3;
    localparam aluOp_t OP_SRL = 4'd4;
    localparam aluOp_t OP_SRA = 4'd5;
    localparam aluOp_t OP_OR  = 4'd6;
    localparam aluOp_t OP_AND = 4'd7;
    localparam aluOp_t OP_EQ  = 4'd8;
    localparam aluOp_t OP_NE  = 4'd9;
    localparam aluOp_t OP_LT  = 4'd10;
    localparam aluOp_t OP_GE  = 4'd11;
    localparam aluOp_t OP_LTU = 4'd12;
    localparam aluOp_t OP_GEU = 4'd13;

endpackage

// File: rtl/rs_alu.sv
// Combinational integer ALU and branch comparator.
module rs_alu
    import rs_pkg::*;
(
    input  aluOp_t      op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] res
);

    logic [4:0] shamt;

    assign shamt = rs2[4:0];

    always_comb begin
        res = '0;
        unique case (op)
            OP_ADD:  res = rs1 + rs2;
            OP_SUB:  res = rs1 - rs2;
            OP_SLL:  res = rs1 << shamt;
            OP_XOR:  res = rs1 ^ rs2;
            OP_SRL:  res = rs1 >> shamt;
            OP_SRA:  res = $unsigned($signed(rs1) >>> shamt);
            OP_OR:   res = rs1 | rs2;
            OP_AND:  res = rs1 & rs2;
            OP_EQ:   res = {31'd0, rs1 == rs2};
            OP_NE:   res = {31'd0, rs1 != rs2};
            OP_LT:   res = {31'd0, $signed(rs1) < $signed(rs2)};
            OP_GE:   res = {31'd0, $signed(rs1) >= $signed(rs2)};
            OP_LTU:  res = {31'd0, rs1 < rs2};
            OP_GEU:  res = {31'd0, rs1 >= rs2};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/age_ordered_reservation_station.sv
// ALU reservation station: CDB wakeup, oldest-ready-first issue via age matrix.
module age_ordered_reservation_station
    import rs_pkg::*;
#(
    parameter int ROB_WIDTH = 4,
    parameter int RS_WIDTH  = 4,
    parameter int NUM_CDB   = 2
) (
    input  logic                         clockIn,
    input  logic                         resetNIn,
    input  logic                         readyIn,
    input  logic                         flushIn,
    input  logic                         addFlag,
    input  logic [OP_W-1:0]              addOp,
    input  logic [31:0]                  addVj,
    input  logic [31:0]                  addVk,
    input  logic [ROB_WIDTH-1:0]         addQj,
    input  logic [ROB_WIDTH-1:0]         addQk,
    input  logic                         addQjBusy,
    input  logic                         addQkBusy,
    input  logic [ROB_WIDTH-1:0]         addDest,
    output logic                         full,
    input  logic [NUM_CDB-1:0]           cdbFlag,
    input  logic [32*NUM_CDB-1:0]        cdbVal,
    input  logic [ROB_WIDTH*NUM_CDB-1:0] cdbDest,
    output logic                         outFlag,
    output logic [31:0]                  outVal,
    output logic [ROB_WIDTH-1:0]         outDest
);

    localparam int N = 1 << RS_WIDTH;

    typedef logic [ROB_WIDTH-1:0] tag_t;

    logic [N-1:0]        busy;
    logic [N-1:0]        qjBusy;
    logic [N-1:0]        qkBusy;
    aluOp_t              op     [N];
    logic [31:0]         vj     [N];
    logic [31:0]         vk     [N];
    tag_t                qj     [N];
    tag_t                qk     [N];
    tag_t                dest   [N];
    logic [N-1:0]        older  [N];

    logic [N-1:0]        ready;
    logic [N-1:0]        issue;
    logic [N-1:0]        colOlder [N];
    logic [RS_WIDTH-1:0] freeIdx;
    logic                anyIssue;
    aluOp_t              selOp;
    logic [31:0]         selVj;
    logic [31:0]         selVk;
    tag_t                selDest;
    logic [31:0]         aluRes;
    logic [32:0]         jSnoop [N];
    logic [32:0]         kSnoop [N];
    logic [32:0]         dj;
    logic [32:0]         dk;

    // Priority: lowest CDB channel, then registered result, then result issuing now.
    function automatic logic [32:0] snoop(input tag_t q, input logic useIss);
        logic [32:0] r;
        r = '0;
        if (useIss && anyIssue && selDest == q) r = {1'b1, aluRes};
        if (outFlag && outDest == q) r = {1'b1, outVal};
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (cdbFlag[c] && cdbDest[c*ROB_WIDTH +: ROB_WIDTH] == q)
                r = {1'b1, cdbVal[c*32 +: 32]};
        end
        return r;
    endfunction

    assign ready = busy & ~qjBusy & ~qkBusy;
    assign full  = &busy;

    generate
        for (genvar i = 0; i < N; i++) begin : gSel
            for (genvar j = 0; j < N; j++) begin : gCol
                assign colOlder[i][j] = older[j][i];
            end
            assign issue[i] = ready[i] & ~|(ready & colOlder[i]);
        end
    endgenerate

    assign anyIssue = |issue;

    always_comb begin
        freeIdx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) freeIdx = RS_WIDTH'(i);
        end
    end

    always_comb begin
        selOp   = '0;
        selVj   = '0;
        selVk   = '0;
        selDest = '0;
        for (int i = 0; i < N; i++) begin
            if (issue[i]) begin
                selOp   = op[i];
                selVj   = vj[i];
                selVk   = vk[i];
                selDest = dest[i];
            end
        end
    end

    rs_alu uAlu (
        .op  (selOp),
        .rs1 (selVj),
        .rs2 (selVk),
        .res (aluRes)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            jSnoop[i] = snoop(qj[i], 1'b1);
            kSnoop[i] = snoop(qk[i], 1'b1);
        end
        dj = snoop(addQj, 1'b0);
        dk = snoop(addQk, 1'b0);
    end

    always_ff @(posedge clockIn or negedge resetNIn) begin
        if (!resetNIn) begin
            busy    <= '0;
            qjBusy  <= '0;
            qkBusy  <= '0;
            outFlag <= 1'b0;
            outVal  <= '0;
            outDest <= '0;
            for (int i = 0; i < N; i++) begin
                op[i]    <= '0;
                vj[i]    <= '0;
                vk[i]    <= '0;
                qj[i]    <= '0;
                qk[i]    <= '0;
                dest[i]  <= '0;
                older[i] <= '0;
            end
        end else if (readyIn) begin
            if (flushIn) begin
                busy    <= '0;
                outFlag <= 1'b0;
            end else begin
                outFlag <= anyIssue;
                if (anyIssue) begin
                    outVal  <= aluRes;
                    outDest <= selDest;
                end
                for (int i = 0; i < N; i++) begin
                    if (issue[i]) begin
                        busy[i] <= 1'b0;
                    end else if (busy[i]) begin
                        if (qjBusy[i] && jSnoop[i][32]) begin
                            vj[i]     <= jSnoop[i][31:0];
                            qjBusy[i] <= 1'b0;
                        end
                        if (qkBusy[i] && kSnoop[i][32]) begin
                            vk[i]     <= kSnoop[i][31:0];
                            qkBusy[i] <= 1'b0;
                        end
                    end
                end
                if (addFlag && !full) begin
                    busy[freeIdx]   <= 1'b1;
                    op[freeIdx]     <= addOp;
                    dest[freeIdx]   <= addDest;
                    qj[freeIdx]     <= addQj;
                    qk[freeIdx]     <= addQk;
                    vj[freeIdx]     <= (addQjBusy && dj[32]) ? dj[31:0] : addVj;
                    vk[freeIdx]     <= (addQkBusy && dk[32]) ? dk[31:0] : addVk;
                    qjBusy[freeIdx] <= addQjBusy && !dj[32];
                    qkBusy[freeIdx] <= addQkBusy && !dk[32];
                    // New entry is younger than everything currently held.
                    for (int k = 0; k < N; k++) begin
                        older[k][freeIdx] <= busy[k];
                    end
                    older[freeIdx] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_age_ordered_reservation_station.sv
// Randomized and directed bench against a queue-based age-order model.
module tb_age_ordered_reservation_station;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rstN;
    logic        rdy;
    logic        flush;
    logic        addFlag;
    logic [3:0]  addOp;
    logic [31:0] addVj;
    logic [31:0] addVk;
    logic [3:0]  addQj;
    logic [3:0]  addQk;
    logic        addQjBusy;
    logic        addQkBusy;
    logic [3:0]  addDest;
    logic        full;
    logic [1:0]  cdbFlag;
    logic [63:0] cdbVal;
    logic [7:0]  cdbDest;
    logic        outFlag;
    logic [31:0] outVal;
    logic [3:0]  outDest;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [3:0]  qj;
        logic [3:0]  qk;
        bit          bj;
        bit          bk;
        logic [3:0]  dest;
    } ent_t;

    ent_t        mq[$];
    bit          mFlag;
    logic [31:0] mVal;
    logic [3:0]  mDest;

    age_ordered_reservation_station dut (
        .clockIn   (clk),
        .resetNIn  (rstN),
        .readyIn   (rdy),
        .flushIn   (flush),
        .addFlag   (addFlag),
        .addOp     (addOp),
        .addVj     (addVj),
        .addVk     (addVk),
        .addQj     (addQj),
        .addQk     (addQk),
        .addQjBusy (addQjBusy),
        .addQkBusy (addQkBusy),
        .addDest   (addDest),
        .full      (full),
        .cdbFlag   (cdbFlag),
        .cdbVal    (cdbVal),
        .cdbDest   (cdbDest),
        .outFlag   (outFlag),
        .outVal    (outVal),
        .outDest   (outDest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rstN && rdy && !flush && addFlag)
            assert (!full) else $error("dispatch into a full station");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refAlu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << b[4:0];
            4'd3:  return a ^ b;
            4'd4:  return a >> b[4:0];
            4'd5:  return $unsigned($signed(a) >>> b[4:0]);
            4'd6:  return a | b;
            4'd7:  return a & b;
            4'd8:  return (a == b) ? 32'd1 : 32'd0;
            4'd9:  return (a != b) ? 32'd1 : 32'd0;
            4'd10: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd11: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            4'd12: return (a < b) ? 32'd1 : 32'd0;
            4'd13: return (a >= b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Value source for a pending tag this cycle, if any.
    function automatic logic [32:0] src(input logic [3:0] q, input bit iss,
                                        input logic [3:0] iDest, input logic [31:0] iVal);
        for (int c = 0; c < 2; c++) begin
            if (cdbFlag[c] && cdbDest[c*4 +: 4] == q) return {1'b1, cdbVal[c*32 +: 32]};
        end
        if (mFlag && mDest == q) return {1'b1, mVal};
        if (iss && iDest == q) return {1'b1, iVal};
        return 33'd0;
    endfunction

    task automatic modelReset();
        mq.delete();
        mFlag = 0;
        mVal  = '0;
        mDest = '0;
    endtask

    task automatic modelStep();
        int          idx;
        int          pre;
        logic [31:0] res;
        logic [3:0]  iDest;
        logic [32:0] s;
        ent_t        e;
        if (!rdy) return;
        if (flush) begin
            mq.delete();
            mFlag = 0;
            return;
        end
        idx = -1;
        res = '0;
        iDest = '0;
        pre = mq.size();
        foreach (mq[i]) if (idx < 0 && !mq[i].bj && !mq[i].bk) idx = i;
        if (idx >= 0) begin
            res = refAlu(mq[idx].op, mq[idx].vj, mq[idx].vk);
            iDest = mq[idx].dest;
        end
        foreach (mq[i]) begin
            if (i != idx) begin
                if (mq[i].bj) begin
                    s = src(mq[i].qj, idx >= 0, iDest, res);
                    if (s[32]) begin mq[i].vj = s[31:0]; mq[i].bj = 0; end
                end
                if (mq[i].bk) begin
                    s = src(mq[i].qk, idx >= 0, iDest, res);
                    if (s[32]) begin mq[i].vk = s[31:0]; mq[i].bk = 0; end
                end
            end
        end
        if (idx >= 0) mq.delete(idx);
        if (addFlag && pre < N) begin
            e.op = addOp;
            e.dest = addDest;
            e.qj = addQj;
            e.qk = addQk;
            s = src(addQj, 0, 4'd0, 32'd0);
            e.bj = addQjBusy && !s[32];
            e.vj = (addQjBusy && s[32]) ? s[31:0] : addVj;
            s = src(addQk, 0, 4'd0, 32'd0);
            e.bk = addQkBusy && !s[32];
            e.vk = (addQkBusy && s[32]) ? s[31:0] : addVk;
            mq.push_back(e);
        end
        mFlag = (idx >= 0);
        if (idx >= 0) begin
            mVal = res;
            mDest = iDest;
        end
    endtask

    task automatic tick();
        chk("full", {31'd0, full}, {31'd0, mq.size() == N});
        modelStep();
        @(posedge clk);
        #1;
        chk("outFlag", {31'd0, outFlag}, {31'd0, mFlag});
        if (mFlag) begin
            chk("outVal", outVal, mVal);
            chk("outDest", {28'd0, outDest}, {28'd0, mDest});
        end
        addFlag = 0;
        cdbFlag = '0;
        flush = 0;
    endtask

    task automatic disp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit ja, input logic [3:0] ta, input bit kb, input logic [3:0] tk,
                        input logic [3:0] d);
        addFlag = 1;
        addOp = o;
        addVj = a;
        addVk = b;
        addQjBusy = ja;
        addQj = ta;
        addQkBusy = kb;
        addQk = tk;
        addDest = d;
    endtask

    task automatic bcast(input int c, input logic [3:0] t, input logic [31:0] v);
        cdbFlag[c] = 1'b1;
        cdbDest[c*4 +: 4] = t;
        cdbVal[c*32 +: 32] = v;
    endtask

    function automatic logic [31:0] rnd();
        return ($urandom % 4 == 0) ? ($urandom % 8) : $urandom;
    endfunction

    initial begin
        int ord[4];
        ord = '{5, 6, 7, 9};
        rstN = 1; rdy = 1; flush = 0; addFlag = 0;
        addOp = '0; addVj = '0; addVk = '0; addQj = '0; addQk = '0;
        addQjBusy = 0; addQkBusy = 0; addDest = '0;
        cdbFlag = '0; cdbVal = '0; cdbDest = '0;
        modelReset();
        #2 rstN = 0;
        #10;
        chk("rstOutFlag", {31'd0, outFlag}, 32'd0);
        chk("rstOutVal", outVal, 32'd0);
        chk("rstOutDest", {28'd0, outDest}, 32'd0);
        chk("rstFull", {31'd0, full}, 32'd0);
        @(negedge clk) rstN = 1;

        // Younger ready op overtakes older waiting op.
        disp(4'd0, 32'd0, 32'd1, 1, 4'd5, 0, 4'd0, 4'd1); tick();
        disp(4'd0, 32'd3, 32'd4, 0, 4'd0, 0, 4'd0, 4'd2); tick();
        tick();
        chk("ageB", outVal, 32'd7);
        chk("ageBdest", {28'd0, outDest}, 32'd2);
        bcast(1, 4'd5, 32'd10); tick();
        chk("ageAwait", {31'd0, outFlag}, 32'd0);
        tick();
        chk("ageA", outVal, 32'd11);
        chk("ageAdest", {28'd0, outDest}, 32'd1);

        // Operand captured from a broadcast in the dispatch cycle.
        disp(4'd1, 32'd5, 32'd0, 0, 4'd0, 1, 4'd9, 4'd3);
        bcast(0, 4'd9, 32'd1); tick();
        tick();
        chk("bypassFlag", {31'd0, outFlag}, 32'd1);
        chk("bypass", outVal, 32'd4);

        // Slot reuse must not change age order.
        disp(4'd0, 32'd0, 32'd8, 1, 4'd13, 0, 4'd0, 4'd8); tick();
        for (int d = 5; d <= 7; d++) begin
            disp(4'd0, 32'd0, 32'(d), 1, 4'd7, 0, 4'd0, 4'(d)); tick();
        end
        bcast(0, 4'd13, 32'd0); tick();
        tick();
        chk("slot0Dest", {28'd0, outDest}, 32'd8);
        disp(4'd0, 32'd0, 32'd9, 1, 4'd7, 0, 4'd0, 4'd9); tick();
        bcast(0, 4'd7, 32'd100); tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("orderDest", {28'd0, outDest}, 32'(ord[i]));
            chk("orderVal", outVal, 32'(100 + ord[i]));
        end

        // Stall holds result; flush ignored while stalled.
        disp(4'd5, 32'h8000_0000, 32'd4, 0, 4'd0, 0, 4'd0, 4'd10); tick();
        disp(4'd0, 32'd0, 32'd1, 1, 4'd11, 0, 4'd0, 4'd12); tick();
        chk("sra", outVal, 32'hF800_0000);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) flush = 1;
            tick();
            chk("holdFlag", {31'd0, outFlag}, 32'd1);
            chk("holdVal", outVal, 32'hF800_0000);
        end
        rdy = 1;
        bcast(0, 4'd11, 32'd5); tick();
        tick();
        chk("stallWake", outVal, 32'd6);
        chk("stallWakeDest", {28'd0, outDest}, 32'd12);

        // Fill completely, then flush with a dispatch in the same cycle.
        for (int i = 0; i < N; i++) begin
            disp(4'd0, 32'd0, 32'(i), 1, 4'd15, 0, 4'd0, 4'(i)); tick();
        end
        chk("fullSet", {31'd0, full}, 32'd1);
        flush = 1;
        disp(4'd0, 32'd1, 32'd1, 0, 4'd0, 0, 4'd0, 4'd3); tick();
        chk("flushFull", {31'd0, full}, 32'd0);
        chk("flushOut", {31'd0, outFlag}, 32'd0);
        bcast(0, 4'd15, 32'd0); tick();
        chk("flushDrop", {31'd0, outFlag}, 32'd0);
        tick();
        chk("flushDrop2", {31'd0, outFlag}, 32'd0);

        // Asynchronous reset with entries in flight.
        for (int i = 0; i < 3; i++) begin
            disp(4'd0, 32'd0, 32'd1, 1, 4'd14, 0, 4'd0, 4'(i)); tick();
        end
        disp(4'd0, 32'd2, 32'd2, 0, 4'd0, 0, 4'd0, 4'd4); tick();
        tick();
        chk("preRst", {31'd0, outFlag}, 32'd1);
        #2 rstN = 0;
        #1;
        chk("midRstFlag", {31'd0, outFlag}, 32'd0);
        chk("midRstFull", {31'd0, full}, 32'd0);
        modelReset();
        @(negedge clk) rstN = 1;
        bcast(0, 4'd14, 32'd0); tick();
        tick();
        chk("midRstNoIssue", {31'd0, outFlag}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            rdy = ($urandom % 8) != 0;
            flush = ($urandom % 64) == 0;
            if (mq.size() < N && ($urandom % 2) == 1)
                disp(4'($urandom % 16), rnd(), rnd(), 1'($urandom % 2), 4'($urandom % 16),
                     ($urandom % 3) == 0, 4'($urandom % 16), 4'($urandom % 16));
            for (int c = 0; c < 2; c++) begin
                if (($urandom % 3) == 0) bcast(c, 4'($urandom % 16), rnd());
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
